wrr_grant_scheduler: RTL and testbench

- Weighted round-robin scheduler that shares one slave resource among N_REQ requesters.
- Grants one requester at a time and holds the grant until that requester's done, or until a watchdog timeout.
- Per-requester weights set how many consecutive transactions a requester may take before priority rotates.
- Sits in front of the shared slave as the sequencing and ownership authority; it replaces the plain request/done/grant arbiter wherever bandwidth shaping is needed.

---
 rtl/wrr_pkg.sv | 16 +
 rtl/wrr_grant_scheduler_rr_pick.sv | 25 ++
 rtl/wrr_grant_scheduler.sv | 160 ++++++++++++++++
 tb/tb_wrr_grant_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// Shared types and default sizing for the weighted round-robin scheduler family.
package wrr_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_TIMEOUT  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        BUSY   = 2'd2
    } state_e;

    typedef logic [$clog2(DEF_N_REQ)-1:0] id_t;

endpackage

// File: rtl/wrr_grant_scheduler_rr_pick.sv
// Rotating priority encoder: first set bit of cand_i at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  cand_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] winner_o
);

    // Scan from the farthest offset down so the closest match to ptr_i is the last write.
    // N is a power of two, so the index addition wraps naturally.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_i[ptr_i + IW'(k)]) begin
                found_o  = 1'b1;
                winner_o = ptr_i + IW'(k);
            end
        end
    end

endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin owner of a shared slave: one-hot registered grant held
// until the owner's done or a watchdog-forced release.
module wrr_grant_scheduler
    import wrr_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                        clock,
    input  logic                        aresetn,
    input  logic [N_REQ-1:0]            request,
    input  logic [N_REQ-1:0]            done,
    input  logic [N_REQ*WEIGHT_W-1:0]   weight_cfg,
    input  logic                        cfg_load,
    output logic [N_REQ-1:0]            grant,
    output logic                        grant_valid,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        timeout_err,
    output logic [$clog2(N_REQ)-1:0]    timeout_id
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic                terr_q, terr_d;
    logic [ID_W-1:0]     tid_q, tid_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [WEIGHT_W-1:0] weight_q [N_REQ];
    logic [WEIGHT_W-1:0] weight_d [N_REQ];
    logic [WEIGHT_W-1:0] credit_q [N_REQ];
    logic [WEIGHT_W-1:0] credit_d [N_REQ];

    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    cand;
    logic                found;
    logic [ID_W-1:0]     winner;
    logic [WEIGHT_W-1:0] cred_dec;

    // A zero weight masks a requester for good; credit only gates the current round.
    always_comb begin
        eligible = '0;
        cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = request[i] && (weight_q[i] != '0);
            cand[i]     = eligible[i] && (credit_q[i] != '0);
        end
    end

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .cand_i   (cand),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    // NOTE: every next-state signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gid_d    = gid_q;
        terr_d   = 1'b0;
        tid_d    = tid_q;
        ptr_d    = ptr_q;
        wd_d     = wd_q;
        credit_d = credit_q;
        weight_d = weight_q;
        cred_dec = (credit_q[gid_q] != '0) ? credit_q[gid_q] - WEIGHT_W'(1) : '0;

        if (cfg_load) begin
            for (int i = 0; i < N_REQ; i++) begin
                weight_d[i] = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = BUSY;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    gid_d           = winner;
                    wd_d            = '0;
                end else if (|eligible) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                credit_d = weight_q;
                state_d  = IDLE;
            end
            BUSY: begin
                // done takes precedence over a watchdog expiry in the same cycle.
                if (done[gid_q]) begin
                    credit_d[gid_q] = cred_dec;
                    ptr_d           = (cred_dec != '0) ? gid_q : gid_q + ID_W'(1);
                    grant_d         = '0;
                    gid_d           = '0;
                    state_d         = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    terr_d          = 1'b1;
                    tid_d           = gid_q;
                    credit_d[gid_q] = '0;
                    ptr_d           = gid_q + ID_W'(1);
                    grant_d         = '0;
                    gid_d           = '0;
                    state_d         = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                gid_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            terr_q  <= 1'b0;
            tid_q   <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            // NOTE: the weight/credit arrays are small flop banks, not RAM, so they are reset like any other state.
            for (int i = 0; i < N_REQ; i++) begin
                weight_q[i] <= WEIGHT_W'(1);
                credit_q[i] <= WEIGHT_W'(1);
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            terr_q   <= terr_d;
            tid_q    <= tid_d;
            ptr_q    <= ptr_d;
            wd_q     <= wd_d;
            weight_q <= weight_d;
            credit_q <= credit_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = gid_q;
    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;

endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// Self-checking bench for wrr_grant_scheduler: vector table, directed corner
// sequences and randomized traffic against an owner/credit reference model.
module tb_wrr_grant_scheduler;
    import wrr_pkg::*;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int TO = 64;

    logic            clock = 1'b0;
    logic            aresetn;
    logic [N-1:0]    request;
    logic [N-1:0]    done;
    logic [N*WW-1:0] weight_cfg;
    logic            cfg_load;
    logic [N-1:0]    grant;
    logic            grant_valid;
    id_t             grant_id;
    logic            timeout_err;
    id_t             timeout_id;

    always #5 clock = ~clock;

    wrr_grant_scheduler #(
        .N_REQ    (N),
        .WEIGHT_W (WW),
        .TIMEOUT  (TO)
    ) dut (
        .clock       (clock),
        .aresetn     (aresetn),
        .request     (request),
        .done        (done),
        .weight_cfg  (weight_cfg),
        .cfg_load    (cfg_load),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: who owns the slave, how long, per-requester credits.
    int m_owner;
    int m_wd;
    int m_ptr;
    int m_w [N];
    int m_c [N];
    int m_tid;
    bit m_refill;
    bit m_terr;

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] dn;
        logic [N-1:0] exp_grant;
        logic [1:0]   exp_id;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int o;
        int idx;
        int winner;
        bit any_elig;
        bit terr_n;
        terr_n = 1'b0;
        if (!aresetn) begin
            m_owner  = -1;
            m_wd     = 0;
            m_ptr    = 0;
            m_refill = 1'b0;
            m_terr   = 1'b0;
            m_tid    = 0;
            for (int i = 0; i < N; i++) begin
                m_w[i] = 1;
                m_c[i] = 1;
            end
            return;
        end
        if (m_owner >= 0) begin
            o = m_owner;
            if (done[o]) begin
                if (m_c[o] > 0) m_c[o] = m_c[o] - 1;
                m_ptr   = (m_c[o] > 0) ? o : (o + 1) % N;
                m_owner = -1;
            end else if (m_wd == TO - 1) begin
                terr_n  = 1'b1;
                m_tid   = o;
                m_c[o]  = 0;
                m_ptr   = (o + 1) % N;
                m_owner = -1;
            end else begin
                m_wd++;
            end
        end else if (m_refill) begin
            for (int i = 0; i < N; i++) m_c[i] = m_w[i];
            m_refill = 1'b0;
        end else begin
            winner   = -1;
            any_elig = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (request[idx] && m_w[idx] != 0) begin
                    any_elig = 1'b1;
                    if (winner < 0 && m_c[idx] > 0) winner = idx;
                end
            end
            if (winner >= 0) begin
                m_owner = winner;
                m_wd    = 0;
            end else if (any_elig) begin
                m_refill = 1'b1;
            end
        end
        if (cfg_load) begin
            for (int i = 0; i < N; i++) m_w[i] = int'(weight_cfg[i*WW +: WW]);
        end
        m_terr = terr_n;
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        model_step();
        @(posedge clock);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("grant", 32'(grant), 32'(eg));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("grant_id", 32'(grant_id), (m_owner >= 0) ? m_owner : 0);
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        check("timeout_id", 32'(timeout_id), m_tid);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        request = '0;
        done    = '0;
        cfg_load = 1'b0;
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int got;
        int order [$];
        int exp_order [10];

        // Request all four, done on each grant's first visible cycle.
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
        tbl[3]  = '{4'b1111, 4'b0010, 4'b0000, 2'd0};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2};
        tbl[5]  = '{4'b1111, 4'b0100, 4'b0000, 2'd0};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3};
        tbl[7]  = '{4'b1111, 4'b1000, 4'b0000, 2'd0};
        tbl[8]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0};  // credits exhausted -> REFILL
        tbl[9]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0};  // REFILL -> IDLE
        tbl[10] = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
        tbl[11] = '{4'b1111, 4'b0001, 4'b0000, 2'd0};

        exp_order = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

        aresetn    = 1'b0;
        request    = '0;
        done       = '0;
        weight_cfg = '0;
        cfg_load   = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        aresetn = 1'b1;

        // Plain round robin from reset defaults.
        for (int v = 0; v < 12; v++) begin
            request = tbl[v].req;
            done    = tbl[v].dn;
            tick();
            check("tbl_grant", 32'(grant), 32'(tbl[v].exp_grant));
            check("tbl_id", 32'(grant_id), 32'(tbl[v].exp_id));
        end
        done = '0;

        // Weights {1,1,1,3}: req0 takes three in a row once the new weights are refilled.
        do_reset();
        weight_cfg = 16'h1113;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        request  = 4'b0011;
        for (int c = 0; c < 80 && order.size() < 10; c++) begin
            tick();
            if (grant != '0) begin
                order.push_back(int'(grant_id));
                done = grant;
            end else begin
                done = '0;
            end
        end
        done = '0;
        check("wrr_grant_count", 32'(order.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            got = (i < order.size()) ? order[i] : -1;
            check("wrr_order", 32'(got), 32'(exp_order[i]));
        end
        request = '0;
        tick();
        tick();

        // Watchdog: req2 never completes; req3 waits behind it.
        do_reset();
        request = 4'b1100;
        tick();
        check("to_first_grant", 32'(grant), 32'b0100);
        hi = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant != 4'b0100) break;
            hi++;
        end
        check("to_hold_cycles", 32'(hi), 32'(TO));
        check("to_err_pulse", 32'(timeout_err), 32'h1);
        check("to_id", 32'(timeout_id), 32'd2);
        tick();
        check("to_next_grant", 32'(grant), 32'b1000);
        check("to_err_single", 32'(timeout_err), 32'h0);
        done = 4'b1000;
        tick();
        done    = '0;
        request = '0;
        tick();
        check("to_id_held", 32'(timeout_id), 32'd2);

        // done on the watchdog's final cycle wins over the timeout.
        do_reset();
        request = 4'b0001;
        tick();
        for (int c = 0; c < TO - 1; c++) tick();
        check("race_still_granted", 32'(grant), 32'b0001);
        done = 4'b0001;
        tick();
        done = '0;
        check("race_released", 32'(grant), 32'h0);
        check("race_no_err", 32'(timeout_err), 32'h0);
        request = '0;
        tick();

        // Foreign done and request drop are ignored while busy.
        do_reset();
        request = 4'b0010;
        tick();
        request = '0;
        done    = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("busy_hold", 32'(grant), 32'b0010);
        end
        done = 4'b0010;
        tick();
        check("busy_release", 32'(grant), 32'h0);
        done = '0;

        // Weight 0 masks req1 permanently; no refill churn.
        do_reset();
        weight_cfg = 16'h1101;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        request  = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("w0_masked", 32'(grant), 32'h0);
        end
        request = 4'b0001;
        tick();
        check("w0_other_ok", 32'(grant), 32'b0001);
        done = 4'b0001;
        tick();
        done = '0;

        // Reset while busy on req3.
        do_reset();
        request = 4'b1000;
        tick();
        check("rb_busy", 32'(grant), 32'b1000);
        aresetn = 1'b0;
        tick();
        check("rb_dropped", 32'(grant), 32'h0);
        check("rb_no_err", 32'(timeout_err), 32'h0);
        aresetn = 1'b1;
        request = 4'b1111;
        tick();
        check("rb_first_after", 32'(grant), 32'b0001);
        done = 4'b0001;
        tick();
        done = '0;

        // Randomized traffic: frequent completions, random weights, rare resets.
        for (int c = 0; c < 3000; c++) begin
            int r;
            aresetn  = ($urandom_range(0, 499) != 0);
            request  = N'($urandom);
            r        = $urandom_range(0, 9);
            done     = (r < 2) ? grant : (r < 6) ? N'($urandom) : '0;
            cfg_load = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) weight_cfg[i*WW +: WW] = WW'($urandom_range(0, 3));
            tick();
        end

        // Randomized traffic with slow owners so the watchdog fires.
        aresetn  = 1'b1;
        cfg_load = 1'b0;
        for (int c = 0; c < 800; c++) begin
            request = N'($urandom);
            done    = ($urandom_range(0, 99) == 0) ? grant : '0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
